instr_register_arbiter: RTL and testbench
=========================================

Name: instr_register_arbiter

Overview:
- Controller that shares the single load port of the 32-entry instruction register between NUM_REQ write requesters.
- Treats the register array as a circular queue: owns write_pointer and read_pointer, and tracks occupancy.
- Sequences reads through a request/response handshake.
- Sits between instruction producers / the consumer and the instruction register; drives every register input except clk.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4).
- DEPTH, 32, entries in the instruction register; must equal 2**$bits(address_t).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  requester i has an instruction pending.
- req_ready  output  NUM_REQ  grant; handshake completes when req_valid[i] && req_ready[i].
- req_opcode  input  NUM_REQ x opcode_t  per-requester opcode.
- req_operand_a  input  NUM_REQ x operand_t  per-requester operand A.
- req_operand_b  input  NUM_REQ x operand_t  per-requester operand B.
- load_en  output  1  register write enable.
- opcode  output  opcode_t  register write opcode.
- operand_a  output  operand_t  register write operand A.
- operand_b  output  operand_t  register write operand B.
- write_pointer  output  address_t  register write address.
- read_pointer  output  address_t  register read address.
- instruction_word  input  instruction_t  register read data (combinational from read_pointer).
- rd_req  input  1  consumer read request.
- rd_busy  output  1  read FSM not IDLE.
- rd_valid  output  1  one-cycle pulse; rd_data valid.
- rd_data  output  instruction_t  captured instruction.
- count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.

Behaviour:
- Reset (asynchronous, any state):
  - load_en=0, opcode=ZERO, operands=0, write_pointer=0, read_pointer=0.
  - Internal wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data='0, state=IDLE.
  - req_ready=0. Entries in flight are discarded.
- Write arbitration (combinational grant):
  - When !full, grant exactly one requester with req_valid, round-robin: search starts at last_grant+1 mod NUM_REQ.
  - req_ready is one-hot or zero; it is 0 whenever full.
- Write issue, at the handshake edge:
  - load_en<=1; opcode/operand_a/operand_b<=granted requester's fields; write_pointer<=wr_ptr.
  - wr_ptr<=wr_ptr+1 (wraps 31->0); count+1; last_grant updates.
- Without a handshake, load_en<=0 at the next edge; data outputs hold.
- Throughput: one write per cycle; register is written one cycle after the grant.
- Read FSM:
  - IDLE: if rd_req && !empty then read_pointer<=rd_ptr, rd_ptr+1 (wrap), count-1, go to ADDR. rd_req while empty is ignored; stay IDLE.
  - ADDR: rd_data<=instruction_word, rd_valid<=1, go to RESP.
  - RESP: rd_valid<=0, go to IDLE.
  - rd_req outside IDLE is ignored. Latency: accept edge to rd_valid high = 2 cycles; peak 1 read per 3 cycles.
- Simultaneous write handshake and read accept: count unchanged; both pointers advance.
- full/empty are evaluated on the pre-edge count:
  - A write granted in cycle N is readable from cycle N+1 onward.
  - A read accepted while full frees a slot for grants from the next cycle.
- Wrap-around: pointer arithmetic is modulo DEPTH via address_t width; count is one bit wider, so full and empty are distinguishable.
- Invariant: count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: INSTR_ARB_FIXED_PRIORITY_EN.
- Defined: round-robin is replaced by fixed priority (lowest index wins); last_grant is unused.
- Undefined: round-robin as above.
- Port list is identical in both builds.

Decomposition:
- Package instr_register_pkg holds:
  - opcode_t, operand_t, address_t, instruction_t (existing types);
  - new rd_state_t enum {IDLE, ADDR, RESP};
  - new constant INSTR_DEPTH=32.
- One sub-module: instr_rr_arbiter (parameter NUM_REQ; inputs req, enable; outputs one-hot grant).
  - Holds last_grant and the INSTR_ARB_FIXED_PRIORITY_EN option.

Test Plan:
- Reset, then req_valid=2'b11 held for 4 cycles (round-robin build):
  - grants alternate 0,1,0,1;
  - write_pointer 0,1,2,3; count=4.
- Requester 0 sends ADD, op_a=5, op_b=3, then rd_req:
  - read_pointer=0;
  - rd_valid pulses 2 cycles after accept with rd_data.opc=ADD, op_a=5, op_b=3.
- Fill 32 entries:
  - full=1 and req_ready=0 while req_valid=1;
  - one read frees a slot; the next write goes to write_pointer=0 (wrap); count back to 32.
- rd_req while empty:
  - no state change, rd_valid stays 0, read_pointer unchanged.
- Same-cycle write grant and read accept with count=5:
  - count stays 5; wr_ptr and rd_ptr both advance.
- Assert reset_n=0 during ADDR with count=7:
  - all outputs return to reset values immediately; rd_valid never pulses; count=0.
- INSTR_ARB_FIXED_PRIORITY_EN build, req_valid=2'b11 for 3 cycles:
  - requester 0 granted all 3 cycles.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the instruction register and its load/read arbiter.
package instr_register_pkg;

  localparam int INSTR_DEPTH = 32'sd32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } rd_state_t;

  localparam instruction_t INSTR_NOP = '{opc: ZERO, op_a: 32'sd0, op_b: 32'sd0};

  // Pointer advance; wraps naturally at the address_t width.
  function automatic address_t ptr_inc(input address_t p);
    return p + 5'd1;
  endfunction

endpackage

// File: rtl/instr_rr_arbiter.sv
// One-hot grant arbiter for the instruction register load port.
// Round-robin by default; define INSTR_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module instr_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_found;

  assign grant = w_grant;

`ifdef INSTR_ARB_FIXED_PRIORITY_EN

  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ reset_n;

  // Fixed priority: first asserted request from index 0 upward.
  always_comb begin
    w_grant = {NUM_REQ{1'b0}};
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (enable && !w_found && req[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

`else

  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_grant_idx;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    w_grant     = {NUM_REQ{1'b0}};
    w_found     = 1'b0;
    w_idx       = {IDX_W{1'b0}};
    w_grant_idx = r_last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last_grant) + k + 32'sd1) % NUM_REQ);
      if (enable && !w_found && req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
        w_grant_idx    = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Reset to the highest index so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= IDX_W'(NUM_REQ - 32'sd1);
    end else if (w_found) begin
      r_last_grant <= w_grant_idx;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

`endif

endmodule

// File: rtl/instr_register_arbiter.sv
// Shares the instruction register load port among NUM_REQ writers and sequences reads as a
// circular queue. Grant policy selectable via INSTR_ARB_FIXED_PRIORITY_EN (see instr_rr_arbiter).
module instr_register_arbiter
  import instr_register_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = INSTR_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  opcode_t                req_opcode    [NUM_REQ],
  input  operand_t               req_operand_a [NUM_REQ],
  input  operand_t               req_operand_b [NUM_REQ],
  output logic                   load_en,
  output opcode_t                opcode,
  output operand_t               operand_a,
  output operand_t               operand_b,
  output address_t               write_pointer,
  output address_t               read_pointer,
  input  instruction_t           instruction_word,
  input  logic                   rd_req,
  output logic                   rd_busy,
  output logic                   rd_valid,
  output instruction_t           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_grant;
  logic               w_enable;
  logic               w_hs;
  logic               w_rd_accept;
  logic               w_full;
  logic               w_empty;
  opcode_t            w_sel_opc;
  operand_t           w_sel_a;
  operand_t           w_sel_b;
  rd_state_t          w_state_nxt;

  logic               r_load_en;
  opcode_t            r_opcode;
  operand_t           r_operand_a;
  operand_t           r_operand_b;
  address_t           r_write_pointer;
  address_t           r_wr_ptr;
  address_t           r_read_pointer;
  address_t           r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  rd_state_t          r_state;
  logic               r_rd_valid;
  instruction_t       r_rd_data;

  // Flags use the pre-edge count, so a read while full frees a slot only from the next cycle.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign w_enable    = reset_n & ~w_full;
  assign w_hs        = |w_grant;
  assign w_rd_accept = (r_state == IDLE) && rd_req && !w_empty;

  instr_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (w_enable),
    .grant   (w_grant)
  );

  // Select the granted requester's fields (grant is one-hot or zero).
  always_comb begin
    w_sel_opc = ZERO;
    w_sel_a   = 32'sd0;
    w_sel_b   = 32'sd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_opc = req_opcode[i];
        w_sel_a   = req_operand_a[i];
        w_sel_b   = req_operand_b[i];
      end else begin
        w_sel_opc = w_sel_opc;
      end
    end
  end

  // Write issue: data outputs hold between writes, load_en pulses per handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_en       <= 1'b0;
      r_opcode        <= ZERO;
      r_operand_a     <= 32'sd0;
      r_operand_b     <= 32'sd0;
      r_write_pointer <= 5'd0;
      r_wr_ptr        <= 5'd0;
    end else if (w_hs) begin
      r_load_en       <= 1'b1;
      r_opcode        <= w_sel_opc;
      r_operand_a     <= w_sel_a;
      r_operand_b     <= w_sel_b;
      r_write_pointer <= r_wr_ptr;
      r_wr_ptr        <= ptr_inc(r_wr_ptr);
    end else begin
      r_load_en       <= 1'b0;
    end
  end

  // Occupancy: simultaneous write and read leave it unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      case ({w_hs, w_rd_accept})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read FSM next state; rd_req outside IDLE is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd_accept) begin
          w_state_nxt = ADDR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ADDR:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read datapath: address presented in ADDR, captured data valid during RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_pointer <= 5'd0;
      r_rd_ptr       <= 5'd0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= INSTR_NOP;
    end else begin
      if (w_rd_accept) begin
        r_read_pointer <= r_rd_ptr;
        r_rd_ptr       <= ptr_inc(r_rd_ptr);
      end else begin
        r_read_pointer <= r_read_pointer;
      end
      if (r_state == ADDR) begin
        r_rd_data <= instruction_word;
      end else begin
        r_rd_data <= r_rd_data;
      end
      r_rd_valid <= (r_state == ADDR);
    end
  end

  assign req_ready     = w_grant;
  assign load_en       = r_load_en;
  assign opcode        = r_opcode;
  assign operand_a     = r_operand_a;
  assign operand_b     = r_operand_b;
  assign write_pointer = r_write_pointer;
  assign read_pointer  = r_read_pointer;
  assign rd_busy       = (r_state != IDLE);
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;

endmodule

// File: tb/tb_instr_register_arbiter.sv
// Self-checking bench for instr_register_arbiter: vector table plus directed corner sequences,
// with a write/read scoreboard fed by a small behavioural model of the queue.
module tb_instr_register_arbiter;
  import instr_register_pkg::*;

  localparam int NR = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_ready;
  opcode_t      req_opcode    [NR];
  operand_t     req_operand_a [NR];
  operand_t     req_operand_b [NR];
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word;
  logic         rd_req = 1'b0;
  logic         rd_busy, rd_valid;
  instruction_t rd_data;
  logic [5:0]   count;
  logic         full, empty;

  int checks = 0;
  int failures = 0;

  typedef struct packed { address_t wp; instruction_t ins; } wr_exp_t;
  typedef struct packed { logic [1:0] v; logic rd; logic [1:0] exp_ready; logic [5:0] exp_count; } vec_t;

  wr_exp_t      wq[$];
  instruction_t rq[$];
  instruction_t model_q[$];
  int           m_count, m_phase, m_last, seq;
  address_t     m_wp, m_rp;
  instruction_t mem [32];
  vec_t         tbl [10];

`ifdef INSTR_ARB_FIXED_PRIORITY_EN
  localparam logic [1:0] ALT = 2'b01;
`else
  localparam logic [1:0] ALT = 2'b10;
`endif

  always #5 clk = ~clk;

  instr_register_arbiter #(.NUM_REQ(NR), .DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .rd_req(rd_req), .rd_busy(rd_busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .full(full), .empty(empty)
  );

  // Instruction register stand-in.
  always @(posedge clk) if (load_en) mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
  assign instruction_word = mem[read_pointer];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop expected writes on load_en, expected reads on rd_valid.
  always @(negedge clk) begin
    wr_exp_t e;
    if (reset_n) begin
      if (load_en) begin
        if (wq.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          e = wq.pop_front();
          chk("write_pointer", write_pointer, e.wp);
          chk("write_data", {opcode, operand_a, operand_b}, e.ins);
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", 1'b1, 1'b0);
        else chk("rd_data", rd_data, rq.pop_front());
      end
    end
  end

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    logic [1:0] g;
    g = 2'b00;
    if (m_count < 32) begin
`ifdef INSTR_ARB_FIXED_PRIORITY_EN
      if (v[0]) g = 2'b01;
      else if (v[1]) g = 2'b10;
`else
      int first;
      first = (m_last == 0) ? 1 : 0;
      if (v[first]) g[first] = 1'b1;
      else if (v[1-first]) g[1-first] = 1'b1;
`endif
    end
    return g;
  endfunction

  task automatic model_reset();
    m_count = 0; m_phase = 0; m_last = 1; m_wp = 5'd0; m_rp = 5'd0;
    wq.delete(); rq.delete(); model_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; rd_req = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One cycle, entered and left just after a falling edge.
  task automatic cyc(input logic [1:0] v, input logic rd, input bit gen, output logic [1:0] seen);
    logic [1:0] eg; logic acc; int gi; address_t exp_rp; instruction_t ins;
    if (gen) begin
      for (int i = 0; i < NR; i++) begin
        req_opcode[i]    = opcode_t'(4'((seq + i) % 8));
        req_operand_a[i] = 100 * i + seq;
        req_operand_b[i] = -(seq * 3 + i);
      end
      seq++;
    end
    req_valid = v; rd_req = rd;
    #1;
    seen = req_ready;
    eg = model_grant(v);
    chk("req_ready", req_ready, eg);
    acc = rd && (m_phase == 0) && (m_count != 0);
    exp_rp = m_rp;
    if (eg != 2'b00) begin
      gi = eg[1] ? 1 : 0;
      ins = '{opc: req_opcode[gi], op_a: req_operand_a[gi], op_b: req_operand_b[gi]};
      wq.push_back('{wp: m_wp, ins: ins});
      model_q.push_back(ins);
      m_wp = m_wp + 5'd1; m_last = gi; m_count++;
    end
    if (acc) begin
      rq.push_back(model_q.pop_front());
      m_rp = m_rp + 5'd1; m_count--; m_phase = 2;
    end else if (m_phase != 0) m_phase--;
    @(negedge clk);
    chk("count", count, m_count);
    chk("full", full, m_count == 32);
    chk("empty", empty, m_count == 0);
    chk("rd_busy", rd_busy, m_phase != 0);
    chk("rd_valid", rd_valid, m_phase == 1);
    if (acc) chk("read_pointer", read_pointer, exp_rp);
  endtask

  initial begin
    logic [1:0] seen;
    tbl[0] = '{2'b11, 1'b0, 2'b01, 6'd1};
    tbl[1] = '{2'b11, 1'b0, ALT,   6'd2};
    tbl[2] = '{2'b11, 1'b0, 2'b01, 6'd3};
    tbl[3] = '{2'b11, 1'b0, ALT,   6'd4};
    tbl[4] = '{2'b01, 1'b0, 2'b01, 6'd5};
    tbl[5] = '{2'b10, 1'b0, 2'b10, 6'd6};
    tbl[6] = '{2'b10, 1'b0, 2'b10, 6'd7};
    tbl[7] = '{2'b00, 1'b1, 2'b00, 6'd6};
    tbl[8] = '{2'b11, 1'b0, 2'b01, 6'd7};
    tbl[9] = '{2'b00, 1'b0, 2'b00, 6'd7};
    seq = 0;
    for (int i = 0; i < NR; i++) begin
      req_opcode[i] = ZERO; req_operand_a[i] = 0; req_operand_b[i] = 0;
    end
    model_reset();

    // Reset values
    req_valid = 2'b11;
    #1 chk("rst_req_ready", req_ready, 2'b00);
    do_reset();
    #1;
    chk("rst_load_en", load_en, 1'b0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_write_pointer", write_pointer, 5'd0);
    chk("rst_read_pointer", read_pointer, 5'd0);
    chk("rst_count", count, 6'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_busy", rd_busy, 1'b0);
    chk("rst_rd_data", rd_data, 68'd0);
    @(negedge clk);

    // Vector table: arbitration order and occupancy
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].rd, 1'b1, seen);
      chk("tbl_ready", seen, tbl[i].exp_ready);
      chk("tbl_count", count, tbl[i].exp_count);
    end
    cyc(2'b00, 1'b0, 1'b0, seen);

    // ADD 5,3 then read back
    do_reset();
    req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3;
    cyc(2'b01, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b1, 1'b0, seen);
    chk("add_read_pointer", read_pointer, 5'd0);
    cyc(2'b00, 1'b0, 1'b0, seen);
    chk("add_rd_valid", rd_valid, 1'b1);
    chk("add_opc", rd_data.opc, ADD);
    chk("add_op_a", rd_data.op_a, 32'd5);
    chk("add_op_b", rd_data.op_b, 32'd3);
    cyc(2'b00, 1'b0, 1'b0, seen);

    // Read request while empty is ignored
    cyc(2'b00, 1'b1, 1'b0, seen);
    cyc(2'b00, 1'b1, 1'b0, seen);
    chk("empty_read_pointer", read_pointer, 5'd0);
    chk("empty_rd_busy", rd_busy, 1'b0);

    // Fill, back-pressure, free one slot, wrap
    do_reset();
    for (int i = 0; i < 32; i++) cyc(2'b01, 1'b0, 1'b1, seen);
    cyc(2'b01, 1'b0, 1'b1, seen);
    chk("full_ready", seen, 2'b00);
    chk("full_flag", full, 1'b1);
    cyc(2'b01, 1'b1, 1'b1, seen);
    chk("full_read_ready", seen, 2'b00);
    cyc(2'b01, 1'b0, 1'b1, seen);
    chk("wrap_ready", seen, 2'b01);
    chk("wrap_write_pointer", write_pointer, 5'd0);
    chk("wrap_count", count, 6'd32);
    cyc(2'b00, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b0, 1'b0, seen);

    // Simultaneous write and read with count=5
    do_reset();
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 1'b1, seen);
    cyc(2'b01, 1'b1, 1'b1, seen);
    chk("simul_count", count, 6'd5);
    chk("simul_write_pointer", write_pointer, 5'd5);
    chk("simul_read_pointer", read_pointer, 5'd0);
    cyc(2'b00, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b1, 1'b0, seen);
    chk("simul_rp_advanced", read_pointer, 5'd1);
    cyc(2'b00, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b0, 1'b0, seen);

    // Reset asserted while the read FSM is in ADDR with count=7
    do_reset();
    for (int i = 0; i < 8; i++) cyc(2'b01, 1'b0, 1'b1, seen);
    cyc(2'b00, 1'b1, 1'b0, seen);
    chk("pre_rst_count", count, 6'd7);
    chk("pre_rst_busy", rd_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", count, 6'd0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_load_en", load_en, 1'b0);
    chk("arst_write_pointer", write_pointer, 5'd0);
    chk("arst_read_pointer", read_pointer, 5'd0);
    chk("arst_rd_busy", rd_busy, 1'b0);
    chk("arst_rd_valid", rd_valid, 1'b0);
    chk("arst_opcode", opcode, ZERO);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_pulse", rd_valid, 1'b0);
    end
    reset_n = 1'b1;
    cyc(2'b00, 1'b0, 1'b0, seen);
    cyc(2'b00, 1'b0, 1'b0, seen);

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
